// File: rtl/game_step_timer.sv
// Game step timer: divides 100 ms ticks into game steps for asteroid motion.
// Define GAME_STEP_SPEEDUP_EN to enable the level/period difficulty ramp.
module game_step_timer #(
  parameter int unsigned PERIOD_W        = 8,
  parameter int unsigned LEVEL_W         = 4,
  parameter int unsigned INIT_PERIOD     = 10,
  parameter int unsigned MIN_PERIOD      = 2,
  parameter int unsigned STEPS_PER_LEVEL = 16
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_tick_in,
  input  logic                i_start,
  input  logic                i_pause,
  input  logic                i_stop,
  output logic                o_step_out,
  output logic                o_running,
  output logic [LEVEL_W-1:0]  o_level,
  output logic [PERIOD_W-1:0] o_period
);

  localparam logic [PERIOD_W-1:0] InitPeriod = PERIOD_W'(INIT_PERIOD);

  if (MIN_PERIOD < 1 || MIN_PERIOD > INIT_PERIOD || INIT_PERIOD >= 2 ** PERIOD_W ||
      STEPS_PER_LEVEL < 1) begin : g_param_check
    $error("game_step_timer: illegal period parameters");
  end

  typedef enum logic [1:0] {StIdle, StRun, StPaused} state_e;

  state_e              r_state;
  logic                r_step_out;
  logic                r_running;
  logic [PERIOD_W-1:0] r_tick_cnt;
  logic [PERIOD_W-1:0] w_period;
  logic                w_last_tick;

`ifdef GAME_STEP_SPEEDUP_EN
  localparam logic [PERIOD_W-1:0] MinPeriod = PERIOD_W'(MIN_PERIOD);
  localparam int unsigned StepW = (STEPS_PER_LEVEL > 1) ? $clog2(STEPS_PER_LEVEL) : 1;
  localparam logic [StepW-1:0] LastStep = StepW'(STEPS_PER_LEVEL - 1);

  logic [StepW-1:0]    r_step_cnt;
  logic [LEVEL_W-1:0]  r_level;
  logic [PERIOD_W-1:0] r_period;

  assign w_period = r_period;
  assign o_level  = r_level;
`else
  assign w_period = InitPeriod;
  assign o_level  = '0;
`endif

  assign o_period    = w_period;
  assign o_step_out  = r_step_out;
  assign o_running   = r_running;
  assign w_last_tick = (r_tick_cnt == w_period - PERIOD_W'(1));

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state    <= StIdle;
      r_step_out <= 1'b0;
      r_running  <= 1'b0;
      r_tick_cnt <= '0;
`ifdef GAME_STEP_SPEEDUP_EN
      r_step_cnt <= '0;
      r_level    <= '0;
      r_period   <= InitPeriod;
`endif
    end else begin
      r_step_out <= 1'b0;
      if (i_stop) begin
        // Stop wins over everything, including a completing tick in the same cycle.
        r_state    <= StIdle;
        r_running  <= 1'b0;
        r_tick_cnt <= '0;
`ifdef GAME_STEP_SPEEDUP_EN
        r_step_cnt <= '0;
        r_level    <= '0;
        r_period   <= InitPeriod;
`endif
      end else begin
        unique case (r_state)
          StIdle: begin
            if (i_start && !i_pause) begin
              r_state    <= StRun;
              r_running  <= 1'b1;
              r_tick_cnt <= '0;
`ifdef GAME_STEP_SPEEDUP_EN
              r_step_cnt <= '0;
              r_level    <= '0;
              r_period   <= InitPeriod;
`endif
            end
          end
          StRun: begin
            if (i_pause) begin
              r_state   <= StPaused;
              r_running <= 1'b0;
            end else if (i_tick_in) begin
              if (w_last_tick) begin
                r_tick_cnt <= '0;
                r_step_out <= 1'b1;
`ifdef GAME_STEP_SPEEDUP_EN
                // Period changes only here, where tick_cnt is already back at zero.
                if (r_step_cnt == LastStep) begin
                  r_step_cnt <= '0;
                  if (r_level != '1) r_level <= r_level + LEVEL_W'(1);
                  if (r_period > MinPeriod) r_period <= r_period - PERIOD_W'(1);
                end else begin
                  r_step_cnt <= r_step_cnt + StepW'(1);
                end
`endif
              end else begin
                r_tick_cnt <= r_tick_cnt + PERIOD_W'(1);
              end
            end
          end
          StPaused: begin
            if (!i_pause) begin
              r_state   <= StRun;
              r_running <= 1'b1;
            end
          end
          default: begin
            r_state   <= StIdle;
            r_running <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_step_timer.sv
// Self-checking bench for game_step_timer: directed vector table, ramp sequence and
// randomized stimulus against a step-count based reference model.
module tb_game_step_timer;

  localparam int unsigned PW   = 8;
  localparam int unsigned LW   = 2;
  localparam int unsigned INIT = 4;
  localparam int unsigned MINP = 2;
  localparam int unsigned SPL  = 2;
`ifdef GAME_STEP_SPEEDUP_EN
  localparam bit Ramp = 1'b1;
`else
  localparam bit Ramp = 1'b0;
`endif

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst_n, tick, start, pause, stop;
  logic          step_out, running;
  logic [LW-1:0] level;
  logic [PW-1:0] period;
  logic          d_step, d_running;
  logic [3:0]    d_level;
  logic [7:0]    d_period;

  game_step_timer #(
    .PERIOD_W(PW), .LEVEL_W(LW), .INIT_PERIOD(INIT), .MIN_PERIOD(MINP), .STEPS_PER_LEVEL(SPL)
  ) dut (
    .i_clock(clk), .i_reset(rst_n), .i_tick_in(tick), .i_start(start), .i_pause(pause),
    .i_stop(stop), .o_step_out(step_out), .o_running(running), .o_level(level),
    .o_period(period)
  );

  game_step_timer dut_def (
    .i_clock(clk), .i_reset(rst_n), .i_tick_in(tick), .i_start(start), .i_pause(pause),
    .i_stop(stop), .o_step_out(d_step), .o_running(d_running), .o_level(d_level),
    .o_period(d_period)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: mode 0 idle, 1 run, 2 paused; level/period derived from steps done.
  int m_mode, m_ticks, m_steps;
  bit m_step;

  function automatic int exp_period(input int steps);
    int p;
    if (!Ramp) return INIT;
    p = INIT - steps / SPL;
    return (p < MINP) ? MINP : p;
  endfunction

  function automatic int exp_level(input int steps);
    int l;
    if (!Ramp) return 0;
    l = steps / SPL;
    return (l > (1 << LW) - 1) ? (1 << LW) - 1 : l;
  endfunction

  task automatic model_update();
    m_step = 1'b0;
    if (!rst_n || stop) begin
      m_mode = 0; m_ticks = 0; m_steps = 0;
    end else if (m_mode == 0) begin
      if (start && !pause) begin
        m_mode = 1; m_ticks = 0; m_steps = 0;
      end
    end else if (m_mode == 1) begin
      if (pause) m_mode = 2;
      else if (tick) begin
        m_ticks++;
        if (m_ticks == exp_period(m_steps)) begin
          m_ticks = 0; m_steps++; m_step = 1'b1;
        end
      end
    end else if (!pause) begin
      m_mode = 1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("step_out", 32'(step_out), 32'(m_step));
    check("running", 32'(running), 32'(m_mode == 1));
    check("level", 32'(level), 32'(exp_level(m_steps)));
    check("period", 32'(period), 32'(exp_period(m_steps)));
  endtask

  task automatic cycle(input bit r, input bit s, input bit p, input bit st, input bit t);
    rst_n = r; start = s; pause = p; stop = st; tick = t;
    @(posedge clk);
    model_update();
    #1;
  endtask

  typedef struct packed {
    bit r; bit s; bit p; bit st; bit t; bit e_step; bit e_run;
  } vec_t;

  vec_t vecs[31];
  int   nsteps;
  bit   rp;

  initial begin
    //          r  s  p st  t  step run
    vecs[0]  = '{0, 0, 0, 0, 1, 0, 0};
    vecs[1]  = '{0, 1, 0, 0, 1, 0, 0};
    vecs[2]  = '{1, 1, 0, 0, 0, 0, 1};
    vecs[3]  = '{1, 0, 0, 0, 1, 0, 1};
    vecs[4]  = '{1, 1, 0, 0, 0, 0, 1};
    vecs[5]  = '{1, 0, 0, 0, 1, 0, 1};
    vecs[6]  = '{1, 0, 0, 0, 1, 0, 1};
    vecs[7]  = '{1, 0, 0, 0, 0, 0, 1};
    vecs[8]  = '{1, 0, 0, 0, 1, 1, 1};
    vecs[9]  = '{1, 0, 0, 0, 0, 0, 1};
    vecs[10] = '{1, 0, 0, 0, 1, 0, 1};
    vecs[11] = '{1, 0, 0, 0, 1, 0, 1};
    vecs[12] = '{1, 0, 0, 0, 1, 0, 1};
    vecs[13] = '{1, 0, 0, 1, 1, 0, 0};
    vecs[14] = '{1, 0, 0, 0, 1, 0, 0};
    vecs[15] = '{1, 1, 1, 0, 0, 0, 0};
    vecs[16] = '{1, 1, 0, 0, 0, 0, 1};
    vecs[17] = '{1, 0, 0, 0, 1, 0, 1};
    vecs[18] = '{1, 0, 1, 0, 1, 0, 0};
    vecs[19] = '{1, 0, 1, 0, 1, 0, 0};
    vecs[20] = '{1, 1, 1, 0, 1, 0, 0};
    vecs[21] = '{1, 0, 0, 0, 0, 0, 1};
    vecs[22] = '{1, 0, 0, 0, 1, 0, 1};
    vecs[23] = '{1, 0, 0, 0, 1, 0, 1};
    vecs[24] = '{1, 0, 0, 0, 1, 1, 1};
    vecs[25] = '{1, 0, 0, 0, 0, 0, 1};
    vecs[26] = '{1, 0, 1, 0, 0, 0, 0};
    vecs[27] = '{1, 0, 1, 1, 0, 0, 0};
    vecs[28] = '{1, 0, 0, 0, 0, 0, 0};
    vecs[29] = '{1, 1, 0, 0, 0, 0, 1};
    vecs[30] = '{1, 1, 0, 1, 0, 0, 0};

    m_mode = 0; m_ticks = 0; m_steps = 0; m_step = 1'b0;
    rst_n = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0; tick = 1'b0;
    @(negedge clk);

    // Directed table: reset, basic period, pause/drop, stop/start priority.
    for (int i = 0; i < 31; i++) begin
      cycle(vecs[i].r, vecs[i].s, vecs[i].p, vecs[i].st, vecs[i].t);
      check($sformatf("vec%0d_step", i), 32'(step_out), 32'(vecs[i].e_step));
      check($sformatf("vec%0d_run", i), 32'(running), 32'(vecs[i].e_run));
      check($sformatf("vec%0d_level", i), 32'(level), 32'(exp_level(m_steps)));
      check($sformatf("vec%0d_period", i), 32'(period), 32'(exp_period(m_steps)));
      if (i == 1) begin
        check("def_reset_step", 32'(d_step), 32'd0);
        check("def_reset_run", 32'(d_running), 32'd0);
        check("def_reset_level", 32'(d_level), 32'd0);
        check("def_reset_period", 32'(d_period), 32'd10);
      end
    end

    // Ramp sequence: 20 ticks, one idle clock between each.
    cycle(0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    nsteps = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1, 0, 0, 0, 1);
      check_model();
      if (step_out === 1'b1) begin
        nsteps++;
        if (nsteps == 6) begin
          check("ramp_level_at6", 32'(level), Ramp ? 32'd3 : 32'd0);
          check("ramp_period_at6", 32'(period), Ramp ? 32'd2 : 32'd4);
        end
      end
      cycle(1, 0, 0, 0, 0);
      check_model();
    end
    check("ramp_step_count", 32'(nsteps), Ramp ? 32'd7 : 32'd5);

    // Randomized run against the model.
    cycle(0, 0, 0, 0, 0);
    check_model();
    rp = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) rp = ~rp;
      cycle($urandom_range(0, 499) != 0, $urandom_range(0, 9) == 0, rp,
            $urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0);
      check_model();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_step_timer.md
Name: game_step_timer

Overview:
- Sits directly downstream of the 100 ms tick timer in the variable-timer path.
- Consumes its 1-clock `tick_in` pulses and counts a programmable number of ticks per game step.
- Emits a 1-clock `step_out` pulse that advances asteroid motion.
- Optionally shortens the step period as the game progresses (difficulty ramp); supports start, pause and stop control from the game FSM.

Parameters:
- PERIOD_W, 8, width of period and tick counters.
- LEVEL_W, 4, width of level counter.
- INIT_PERIOD, 10, ticks per step at level 0 (1.0 s at 100 ms ticks); must satisfy 1 <= MIN_PERIOD <= INIT_PERIOD < 2^PERIOD_W.
- MIN_PERIOD, 2, floor for the step period in ticks.
- STEPS_PER_LEVEL, 16, steps between level increments; must be >= 1.

Ports:
- clock  input  1  system clock (50 MHz).
- reset  input  1  synchronous, active-low reset.
- tick_in  input  1  1-clock pulse from the 100 ms timer.
- start  input  1  level pulse; begins a run from IDLE.
- pause  input  1  level; while high in RUN/PAUSED, step counting is frozen.
- stop  input  1  pulse; returns to IDLE from any state.
- step_out  output  1  1-clock pulse per completed step period.
- running  output  1  high in RUN state only.
- level  output  LEVEL_W  current difficulty level.
- period  output  PERIOD_W  current ticks-per-step.

Behaviour:
- One clock; reset is synchronous, active-low, sampled on posedge clock.
- Reset values:
  - state = IDLE
  - step_out = 0, running = 0
  - level = 0, period = INIT_PERIOD
  - tick_cnt = 0, step_cnt = 0
- States: IDLE, RUN, PAUSED.
- Control priority (highest first): reset, stop, pause, start, tick_in.
- IDLE:
  - step_out held 0; ticks ignored.
  - start = 1 and pause = 0 -> RUN, with tick_cnt = 0, step_cnt = 0, level = 0, period = INIT_PERIOD.
  - start with pause = 1 -> stays IDLE.
- RUN:
  - stop -> IDLE; counters cleared, level and period reset as in IDLE entry.
  - pause = 1 -> PAUSED. A tick in the same cycle is dropped.
  - start is ignored.
  - On tick_in: if tick_cnt == period-1, then tick_cnt = 0 and step_out = 1 in the next cycle; otherwise tick_cnt increments.
  - Step completion also updates step_cnt; see the speed-up rules below.
- PAUSED:
  - tick_cnt, step_cnt, level and period are held; ticks are ignored; running = 0.
  - pause = 0 -> RUN, resuming from the held tick_cnt.
  - stop -> IDLE.
- step_out:
  - Registered; asserted exactly one clock, in the cycle after the completing tick_in.
  - Never asserted in IDLE or PAUSED, and never on the cycle after a stop.
- Speed-up (feature enabled), applied in the same clock as the completing tick:
  - step_cnt == STEPS_PER_LEVEL-1 -> step_cnt = 0; level increments, saturating at 2^LEVEL_W-1; period decrements, saturating at MIN_PERIOD.
  - Otherwise step_cnt increments.
- A new period takes effect from the next step. tick_cnt is always 0 at a period change, so it never exceeds period-1.
- Latency: start to the first step_out = INIT_PERIOD ticks + 1 clock.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: GAME_STEP_SPEEDUP_EN.
- Defined:
  - level and period ramp as described above.
  - step_cnt is implemented.
- Undefined:
  - step_cnt logic is removed; level is constant 0; period is constant INIT_PERIOD.
  - All other behaviour is identical.

Test Plan:
- Reset check: reset = 0 for 2 clocks with ticks toggling -> step_out = 0, running = 0, level = 0, period = INIT_PERIOD (10).
- Basic period: INIT_PERIOD = 3; start, then 9 ticks spaced 5 clocks apart -> exactly 3 step_out pulses, each 1 clock wide, one clock after ticks 3, 6 and 9.
- Pause and hold: INIT_PERIOD = 3; 2 ticks, pause = 1, 4 ticks, pause = 0, 1 tick -> step_out only after the final tick. A tick coincident with the pause rising edge is dropped.
- Speed-up and saturation (macro defined): INIT_PERIOD = 4, MIN_PERIOD = 2, STEPS_PER_LEVEL = 2; run 20 ticks.
  - Period sequence 4, 4, 3, 3, 2, 2, 2…
  - level reads 3 after the 6th step; period never goes below 2.
- Macro undefined, same stimulus -> period stays 4, level stays 0, step every 4 ticks.
- Priority: stop and tick_in in the same cycle that completes a period -> no step_out, state IDLE, level = 0. A start while in RUN has no effect on tick_cnt.
